// File: rtl/dbg_cmd_queue.sv
// Buffers host command words and issues them on a stream, consuming local DELAY words as timed stalls.
// Latency: push to empty idle queue -> cmd_out valid after next edge; host_TREADY low when full or flushing.
module dbg_cmd_queue #(
   parameter int         DEPTH        = 16,
   parameter logic [3:0] DELAY_OPCODE = 4'hF,
   parameter int         CNT_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              host_TDATA,
   input  logic                     host_TVALID,
   output logic                     host_TREADY,
   output logic [31:0]              cmd_out_TDATA,
   output logic                     cmd_out_TVALID,
   input  logic                     cmd_out_TREADY,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     delay_active,
   output logic                     busy,
   output logic [CNT_WIDTH-1:0]     issued_cnt
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DELAY} state_t;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [27:0]   dly_cnt, dly_cnt_nxt;
   state_t        state, state_nxt;
   logic [31:0]   out_dat_nxt;
   logic          out_vld_nxt;
   logic          push, pop, full, empty, hs, eval;
   logic [31:0]   head;
   logic          head_is_dly;

   assign full         = (count == (AW+1)'(DEPTH));
   assign empty        = (count == '0);
   assign host_TREADY  = rst && !full && !flush;
   assign push         = host_TVALID && host_TREADY;
   assign hs           = cmd_out_TVALID && cmd_out_TREADY;
   assign head         = mem[rd_ptr];
   assign head_is_dly  = (head[31:28] == DELAY_OPCODE);
   assign fill_level   = count;
   assign delay_active = (state == S_DELAY);
   assign busy         = !empty || (state != S_IDLE);

   // Head is evaluated from IDLE, or from ISSUE on the handshake cycle so commands stream back-to-back.
   always_comb begin
      state_nxt   = state;
      dly_cnt_nxt = dly_cnt;
      out_vld_nxt = cmd_out_TVALID;
      out_dat_nxt = cmd_out_TDATA;
      pop         = 1'b0;
      eval        = 1'b0;
      case (state)
         S_IDLE:  eval = 1'b1;
         S_ISSUE: eval = hs;
         S_DELAY: begin
            if (flush || dly_cnt == 28'd1) begin
               state_nxt   = S_IDLE;
               dly_cnt_nxt = '0;
            end else begin
               dly_cnt_nxt = dly_cnt - 28'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (eval) begin
         out_vld_nxt = 1'b0;
         state_nxt   = S_IDLE;
         if (!flush && !empty) begin
            pop = 1'b1;
            if (!head_is_dly) begin
               out_dat_nxt = head;
               out_vld_nxt = 1'b1;
               state_nxt   = S_ISSUE;
            end else if (head[27:0] != 28'd0) begin
               dly_cnt_nxt = head[27:0];
               state_nxt   = S_DELAY;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         dly_cnt        <= '0;
         issued_cnt     <= '0;
         cmd_out_TDATA  <= '0;
         cmd_out_TVALID <= 1'b0;
      end else begin
         state          <= state_nxt;
         dly_cnt        <= dly_cnt_nxt;
         cmd_out_TDATA  <= out_dat_nxt;
         cmd_out_TVALID <= out_vld_nxt;
         if (hs)
            issued_cnt <= issued_cnt + CNT_WIDTH'(1);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         end
      end
   end

   // Storage needs no reset: count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= host_TDATA;
   end

endmodule

// File: tb/tb_dbg_cmd_queue.sv
// Directed bench for dbg_cmd_queue: ordering, DELAY timing, full/flush behaviour and async reset.
module tb_dbg_cmd_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] host_TDATA = '0;
   logic        host_TVALID = 1'b0;
   logic        host_TREADY;
   logic [31:0] cmd_out_TDATA;
   logic        cmd_out_TVALID;
   logic        cmd_out_TREADY = 1'b0;
   logic        flush = 1'b0;
   logic [4:0]  fill_level;
   logic        delay_active;
   logic        busy;
   logic [15:0] issued_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int exp_issued = 0;
   logic [31:0] log_dat[$];
   int          log_cyc[$];

   dbg_cmd_queue dut (
      .clk(clk), .rst(rst),
      .host_TDATA(host_TDATA), .host_TVALID(host_TVALID), .host_TREADY(host_TREADY),
      .cmd_out_TDATA(cmd_out_TDATA), .cmd_out_TVALID(cmd_out_TVALID), .cmd_out_TREADY(cmd_out_TREADY),
      .flush(flush), .fill_level(fill_level), .delay_active(delay_active), .busy(busy),
      .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst && cmd_out_TVALID && cmd_out_TREADY) begin
         log_dat.push_back(cmd_out_TDATA);
         log_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (cmd_out_TVALID !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", cmd_out_TVALID); end
      n_cmp++; if (cmd_out_TDATA !== 32'h0) begin n_err++; $display("FAIL rst_dat: got %h want 0", cmd_out_TDATA); end
      n_cmp++; if (host_TREADY !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got %b want 0", host_TREADY); end
      n_cmp++; if (fill_level !== 5'd0) begin n_err++; $display("FAIL rst_fill: got %0d want 0", fill_level); end
      n_cmp++; if (issued_cnt !== 16'd0) begin n_err++; $display("FAIL rst_issued: got %0d want 0", issued_cnt); end
      n_cmp++; if (busy !== 1'b0 || delay_active !== 1'b0) begin n_err++; $display("FAIL rst_busy_dly: got %b%b want 00", busy, delay_active); end
      #19 rst = 1'b1;
      step();
      n_cmp++; if (host_TREADY !== 1'b1) begin n_err++; $display("FAIL rst_release_rdy: got %b want 1", host_TREADY); end
   endtask

   task automatic test_in_order();
      log_dat.delete(); log_cyc.delete();
      cmd_out_TREADY = 1'b1;
      host_TDATA = 32'h1; host_TVALID = 1'b1;
      step();
      n_cmp++; if (fill_level !== 5'd1 || cmd_out_TVALID !== 1'b0) begin n_err++; $display("FAIL order_first_push: got fill %0d vld %b want 1 0", fill_level, cmd_out_TVALID); end
      host_TDATA = 32'h2;
      step();
      n_cmp++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 32'h1) begin n_err++; $display("FAIL order_w1: got %b %h want 1 00000001", cmd_out_TVALID, cmd_out_TDATA); end
      host_TDATA = 32'h3;
      step();
      n_cmp++; if (cmd_out_TDATA !== 32'h2) begin n_err++; $display("FAIL order_w2: got %h want 00000002", cmd_out_TDATA); end
      host_TVALID = 1'b0;
      step();
      n_cmp++; if (cmd_out_TDATA !== 32'h3 || cmd_out_TVALID !== 1'b1) begin n_err++; $display("FAIL order_w3: got %b %h want 1 00000003", cmd_out_TVALID, cmd_out_TDATA); end
      step();
      exp_issued += 3;
      n_cmp++; if (cmd_out_TVALID !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL order_idle: got vld %b busy %b want 0 0", cmd_out_TVALID, busy); end
      n_cmp++; if (issued_cnt !== 16'(exp_issued)) begin n_err++; $display("FAIL order_issued: got %0d want %0d", issued_cnt, exp_issued); end
      n_cmp++;
      if (log_dat.size() != 3) begin n_err++; $display("FAIL order_log_size: got %0d want 3", log_dat.size()); end
      else if (log_dat[0] !== 32'h1 || log_dat[1] !== 32'h2 || log_dat[2] !== 32'h3 ||
               log_cyc[1] != log_cyc[0] + 1 || log_cyc[2] != log_cyc[1] + 1) begin
         n_err++; $display("FAIL order_log: got %h %h %h want 1 2 3 on consecutive cycles", log_dat[0], log_dat[1], log_dat[2]);
      end
   endtask

   task automatic test_delay();
      int dcount;
      log_dat.delete(); log_cyc.delete();
      cmd_out_TREADY = 1'b1;
      host_TDATA = 32'h0000_00AA; host_TVALID = 1'b1;
      step();
      host_TDATA = 32'hF000_0005;
      step();
      n_cmp++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 32'hAA) begin n_err++; $display("FAIL delay_aa: got %b %h want 1 000000aa", cmd_out_TVALID, cmd_out_TDATA); end
      host_TDATA = 32'h0000_00BB;
      step();
      host_TVALID = 1'b0;
      n_cmp++; if (delay_active !== 1'b1 || cmd_out_TVALID !== 1'b0) begin n_err++; $display("FAIL delay_enter: got dly %b vld %b want 1 0", delay_active, cmd_out_TVALID); end
      dcount = 1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (delay_active) dcount++;
         else break;
      end
      n_cmp++; if (dcount != 5) begin n_err++; $display("FAIL delay_len: got %0d want 5", dcount); end
      n_cmp++; if (cmd_out_TVALID !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL delay_exit_idle: got vld %b busy %b want 0 1", cmd_out_TVALID, busy); end
      step();
      n_cmp++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 32'hBB) begin n_err++; $display("FAIL delay_bb: got %b %h want 1 000000bb", cmd_out_TVALID, cmd_out_TDATA); end
      step();
      exp_issued += 2;
      n_cmp++;
      if (log_dat.size() != 2) begin n_err++; $display("FAIL delay_log_size: got %0d want 2", log_dat.size()); end
      else if (log_dat[0] !== 32'hAA || log_dat[1] !== 32'hBB) begin n_err++; $display("FAIL delay_log: got %h %h want aa bb", log_dat[0], log_dat[1]); end
      n_cmp++; if (issued_cnt !== 16'(exp_issued)) begin n_err++; $display("FAIL delay_issued: got %0d want %0d", issued_cnt, exp_issued); end
   endtask

   task automatic test_full();
      int bad_order;
      log_dat.delete(); log_cyc.delete();
      cmd_out_TREADY = 1'b0;
      for (int i = 0; i < 17; i++) begin
         host_TDATA = 32'h100 + 32'(i); host_TVALID = 1'b1;
         n_cmp++; if (host_TREADY !== 1'b1) begin n_err++; $display("FAIL full_push_rdy%0d: got %b want 1", i, host_TREADY); end
         step();
      end
      host_TVALID = 1'b0;
      n_cmp++; if (fill_level !== 5'd16 || host_TREADY !== 1'b0) begin n_err++; $display("FAIL full_level: got fill %0d rdy %b want 16 0", fill_level, host_TREADY); end
      step(); step(); step();
      n_cmp++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 32'h100) begin n_err++; $display("FAIL full_hold: got %b %h want 1 00000100", cmd_out_TVALID, cmd_out_TDATA); end
      cmd_out_TREADY = 1'b1;
      #1;
      n_cmp++; if (host_TREADY !== 1'b0) begin n_err++; $display("FAIL full_rdy_during_pop: got %b want 0", host_TREADY); end
      step();
      n_cmp++; if (host_TREADY !== 1'b1 || fill_level !== 5'd15) begin n_err++; $display("FAIL full_rdy_after_pop: got rdy %b fill %0d want 1 15", host_TREADY, fill_level); end
      for (int i = 0; i < 40 && log_dat.size() < 17; i++) step();
      step();
      exp_issued += 17;
      bad_order = 0;
      for (int i = 0; i < log_dat.size(); i++)
         if (log_dat[i] !== 32'h100 + 32'(i)) bad_order++;
      n_cmp++; if (log_dat.size() != 17 || bad_order != 0) begin n_err++; $display("FAIL full_drain: got %0d words %0d out of order want 17 0", log_dat.size(), bad_order); end
      n_cmp++; if (busy !== 1'b0 || issued_cnt !== 16'(exp_issued)) begin n_err++; $display("FAIL full_end: got busy %b issued %0d want 0 %0d", busy, issued_cnt, exp_issued); end
   endtask

   task automatic test_flush();
      log_dat.delete(); log_cyc.delete();
      cmd_out_TREADY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         host_TDATA = 32'h200 + 32'(i); host_TVALID = 1'b1;
         step();
      end
      host_TVALID = 1'b1; host_TDATA = 32'h2FF;
      flush = 1'b1;
      #1;
      n_cmp++; if (host_TREADY !== 1'b0) begin n_err++; $display("FAIL flush_rdy: got %b want 0", host_TREADY); end
      step();
      flush = 1'b0; host_TVALID = 1'b0;
      n_cmp++; if (fill_level !== 5'd0) begin n_err++; $display("FAIL flush_fill: got %0d want 0", fill_level); end
      n_cmp++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 32'h200) begin n_err++; $display("FAIL flush_pending: got %b %h want 1 00000200", cmd_out_TVALID, cmd_out_TDATA); end
      cmd_out_TREADY = 1'b1;
      step(); step(); step();
      exp_issued += 1;
      n_cmp++;
      if (log_dat.size() != 1) begin n_err++; $display("FAIL flush_log_size: got %0d want 1", log_dat.size()); end
      else if (log_dat[0] !== 32'h200) begin n_err++; $display("FAIL flush_log: got %h want 00000200", log_dat[0]); end
      n_cmp++; if (cmd_out_TVALID !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL flush_idle: got vld %b busy %b want 0 0", cmd_out_TVALID, busy); end
   endtask

   task automatic test_delay_flush();
      log_dat.delete(); log_cyc.delete();
      cmd_out_TREADY = 1'b1;
      host_TDATA = 32'hF000_0100; host_TVALID = 1'b1;
      step();
      host_TVALID = 1'b0;
      step();
      repeat (5) step();
      n_cmp++; if (delay_active !== 1'b1) begin n_err++; $display("FAIL dflush_in_delay: got %b want 1", delay_active); end
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++; if (delay_active !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL dflush_idle: got dly %b busy %b want 0 0", delay_active, busy); end
      host_TDATA = 32'h300; host_TVALID = 1'b1;
      step();
      host_TVALID = 1'b0;
      step();
      n_cmp++; if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 32'h300) begin n_err++; $display("FAIL dflush_issue: got %b %h want 1 00000300", cmd_out_TVALID, cmd_out_TDATA); end
      step();
      exp_issued += 1;
      n_cmp++; if (issued_cnt !== 16'(exp_issued)) begin n_err++; $display("FAIL dflush_issued: got %0d want %0d", issued_cnt, exp_issued); end
   endtask

   task automatic test_async_reset();
      cmd_out_TREADY = 1'b0;
      host_TDATA = 32'h400; host_TVALID = 1'b1;
      step();
      host_TDATA = 32'h401;
      step();
      host_TVALID = 1'b0;
      n_cmp++; if (cmd_out_TVALID !== 1'b1 || fill_level !== 5'd1) begin n_err++; $display("FAIL areset_pre: got vld %b fill %0d want 1 1", cmd_out_TVALID, fill_level); end
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (cmd_out_TVALID !== 1'b0 || fill_level !== 5'd0 || issued_cnt !== 16'd0) begin
         n_err++; $display("FAIL areset_clear: got vld %b fill %0d issued %0d want 0 0 0", cmd_out_TVALID, fill_level, issued_cnt);
      end
      #10 rst = 1'b1;
      step(); step();
      n_cmp++; if (cmd_out_TVALID !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL areset_after: got vld %b busy %b want 0 0", cmd_out_TVALID, busy); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_delay();
      test_full();
      test_flush();
      test_delay_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
